// File: rtl/axi_gp_pkg.sv
// Shared widths, response codes and FSM state encoding for the MAXIGP0 register bridge.
package axi_gp_pkg;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 12;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 32;
  localparam int RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

endpackage

// File: rtl/axi_gp_reg_bridge.sv
// AXI3 slave endpoint for PS7 MAXIGP0: serialises AR/AW/W bursts into single-word
// register accesses and returns R/B. One transaction in flight at a time.
module axi_gp_reg_bridge
  import axi_gp_pkg::*;
#(
  parameter int          REG_AW = 10,
  parameter logic [31:0] BASE   = 32'h4000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  // read address
  input  logic              MAXIGP0_O_AR__ENA,
  input  logic [ADDR_W-1:0] MAXIGP0_O_AR_addr,
  input  logic [ID_W-1:0]   MAXIGP0_O_AR_id,
  input  logic [LEN_W-1:0]  MAXIGP0_O_AR_len,
  output logic              MAXIGP0_O_AR__RDY,
  // write address
  input  logic              MAXIGP0_O_AW__ENA,
  input  logic [ADDR_W-1:0] MAXIGP0_O_AW_addr,
  input  logic [ID_W-1:0]   MAXIGP0_O_AW_id,
  input  logic [LEN_W-1:0]  MAXIGP0_O_AW_len,
  output logic              MAXIGP0_O_AW__RDY,
  // write data
  input  logic              MAXIGP0_O_W__ENA,
  input  logic [DATA_W-1:0] MAXIGP0_O_W_data,
  input  logic [ID_W-1:0]   MAXIGP0_O_W_id,
  input  logic              MAXIGP0_O_W_last,
  output logic              MAXIGP0_O_W__RDY,
  // read data
  output logic              MAXIGP0_I_R__ENA,
  output logic [DATA_W-1:0] MAXIGP0_I_R_data,
  output logic [ID_W-1:0]   MAXIGP0_I_R_id,
  output logic              MAXIGP0_I_R_last,
  output logic [RESP_W-1:0] MAXIGP0_I_R_resp,
  input  logic              MAXIGP0_I_R__RDY,
  // write response
  output logic              MAXIGP0_I_B__ENA,
  output logic [ID_W-1:0]   MAXIGP0_I_B_id,
  output logic [RESP_W-1:0] MAXIGP0_I_B_resp,
  input  logic              MAXIGP0_I_B__RDY,
  // register request
  output logic              req__ENA,
  output logic              req_write,
  output logic [REG_AW-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  input  logic              req__RDY,
  // register read return
  input  logic              rsp__ENA,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp__RDY
);

  state_t              state;
  logic                idle_rdy;   // registered "IDLE and ready to accept" flag
  logic                rr_wr;      // 1: write wins the next AR/AW contention
  logic [REG_AW-1:0]   waddr;
  logic [ID_W-1:0]     id;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    beat;
  logic                err;
  logic                oow;
  logic                req_ena_q, req_write_q, rsp_rdy_q, w_rdy;
  logic [DATA_W-1:0]   req_data_q;
  logic                r_ena, r_last;
  logic [DATA_W-1:0]   r_data;
  logic [RESP_W-1:0]   r_resp;
  logic                b_ena;
  logic [RESP_W-1:0]   b_resp;
  logic                ar_go, aw_go, w_go, last_beat;

  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:REG_AW+2] == BASE[ADDR_W-1:REG_AW+2];
  endfunction

  // Ready gating in IDLE: the losing channel sees RDY low so only one
  // address beat can ever transfer in a given cycle.
  assign MAXIGP0_O_AR__RDY = idle_rdy && !(MAXIGP0_O_AW__ENA && rr_wr);
  assign MAXIGP0_O_AW__RDY = idle_rdy && !(MAXIGP0_O_AR__ENA && !rr_wr);

  assign ar_go     = MAXIGP0_O_AR__ENA && MAXIGP0_O_AR__RDY;
  assign aw_go     = MAXIGP0_O_AW__ENA && MAXIGP0_O_AW__RDY;
  assign w_go      = MAXIGP0_O_W__ENA && w_rdy;
  assign last_beat = (beat == len);

  assign MAXIGP0_O_W__RDY = w_rdy;
  assign MAXIGP0_I_R__ENA = r_ena;
  assign MAXIGP0_I_R_data = r_data;
  assign MAXIGP0_I_R_id   = id;
  assign MAXIGP0_I_R_last = r_last;
  assign MAXIGP0_I_R_resp = r_resp;
  assign MAXIGP0_I_B__ENA = b_ena;
  assign MAXIGP0_I_B_id   = id;
  assign MAXIGP0_I_B_resp = b_resp;
  assign req__ENA         = req_ena_q;
  assign req_write        = req_write_q;
  assign req_addr         = waddr;
  assign req_data         = req_data_q;
  assign rsp__RDY         = rsp_rdy_q;

  // Byte lanes and W id carry no meaning for word registers.
  logic unused_bits;
  assign unused_bits = ^{MAXIGP0_O_AR_addr[1:0], MAXIGP0_O_AW_addr[1:0], MAXIGP0_O_W_id};

  // Transaction FSM: every output flag is set on entry to the state that owns it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idle_rdy    <= 1'b0;
      rr_wr       <= 1'b0;
      waddr       <= '0;
      id          <= '0;
      len         <= '0;
      beat        <= '0;
      err         <= 1'b0;
      oow         <= 1'b0;
      req_ena_q   <= 1'b0;
      req_write_q <= 1'b0;
      req_data_q  <= '0;
      rsp_rdy_q   <= 1'b0;
      w_rdy       <= 1'b0;
      r_ena       <= 1'b0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_resp      <= '0;
      b_ena       <= 1'b0;
      b_resp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (MAXIGP0_O_AR__ENA && MAXIGP0_O_AW__ENA && idle_rdy) rr_wr <= ~rr_wr;
          if (ar_go) begin
            idle_rdy <= 1'b0;
            waddr    <= MAXIGP0_O_AR_addr[REG_AW+1:2];
            id       <= MAXIGP0_O_AR_id;
            len      <= MAXIGP0_O_AR_len;
            beat     <= '0;
            err      <= 1'b0;
            oow      <= !in_window(MAXIGP0_O_AR_addr);
            if (in_window(MAXIGP0_O_AR_addr)) begin
              req_ena_q   <= 1'b1;
              req_write_q <= 1'b0;
              state       <= RD_REQ;
            end else begin
              // out-of-window reads go straight to DECERR beats
              r_ena  <= 1'b1;
              r_data <= '0;
              r_resp <= RESP_DECERR;
              r_last <= (MAXIGP0_O_AR_len == '0);
              state  <= RD_RESP;
            end
          end else if (aw_go) begin
            idle_rdy <= 1'b0;
            waddr    <= MAXIGP0_O_AW_addr[REG_AW+1:2];
            id       <= MAXIGP0_O_AW_id;
            len      <= MAXIGP0_O_AW_len;
            beat     <= '0;
            err      <= 1'b0;
            oow      <= !in_window(MAXIGP0_O_AW_addr);
            w_rdy    <= 1'b1;
            state    <= WR_DATA;
          end
        end
        RD_REQ: begin
          if (req__RDY) begin
            req_ena_q <= 1'b0;
            rsp_rdy_q <= 1'b1;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rsp__ENA) begin
            rsp_rdy_q <= 1'b0;
            r_ena     <= 1'b1;
            r_data    <= rsp_data;
            r_resp    <= RESP_OKAY;
            r_last    <= last_beat;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (MAXIGP0_I_R__RDY) begin
            if (r_last) begin
              r_ena    <= 1'b0;
              idle_rdy <= 1'b1;
              state    <= IDLE;
            end else begin
              beat  <= beat + LEN_W'(1);
              waddr <= waddr + REG_AW'(1);
              if (oow) begin
                r_last <= ((beat + LEN_W'(1)) == len);
              end else begin
                r_ena       <= 1'b0;
                req_ena_q   <= 1'b1;
                req_write_q <= 1'b0;
                state       <= RD_REQ;
              end
            end
          end
        end
        WR_DATA: begin
          if (w_go) begin
            if (MAXIGP0_O_W_last != last_beat) err <= 1'b1;
            if (oow) begin
              // drain exactly len+1 beats without touching registers
              if (last_beat) begin
                w_rdy  <= 1'b0;
                b_ena  <= 1'b1;
                b_resp <= RESP_DECERR;
                state  <= WR_RESP;
              end else begin
                beat <= beat + LEN_W'(1);
              end
            end else begin
              w_rdy       <= 1'b0;
              req_ena_q   <= 1'b1;
              req_write_q <= 1'b1;
              req_data_q  <= MAXIGP0_O_W_data;
              state       <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (req__RDY) begin
            req_ena_q <= 1'b0;
            if (last_beat) begin
              b_ena  <= 1'b1;
              b_resp <= err ? RESP_SLVERR : RESP_OKAY;
              state  <= WR_RESP;
            end else begin
              beat  <= beat + LEN_W'(1);
              waddr <= waddr + REG_AW'(1);
              w_rdy <= 1'b1;
              state <= WR_DATA;
            end
          end
        end
        WR_RESP: begin
          if (MAXIGP0_I_B__RDY) begin
            b_ena    <= 1'b0;
            idle_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_gp_reg_bridge.sv
// Directed bench for axi_gp_reg_bridge with a small register-file responder.
module tb_axi_gp_reg_bridge;

  logic        clk, rst;
  logic        ar_ena, ar_rdy, aw_ena, aw_rdy, w_ena, w_rdy, w_last;
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [11:0] ar_id, aw_id, w_id;
  logic [3:0]  ar_len, aw_len;
  logic        r_ena, r_last, r_rdy, b_ena, b_rdy;
  logic [31:0] r_data;
  logic [11:0] r_id, b_id;
  logic [1:0]  r_resp, b_resp;
  logic        req_ena, req_write, req_rdy, rsp_ena, rsp_rdy;
  logic [9:0]  req_addr;
  logic [31:0] req_data, rsp_data;

  int checks = 0, passes = 0, cyc = 0;

  logic [31:0] regs [0:1023];
  int          log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_data[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic        rq_last[$];
  logic [11:0] rq_id[$];
  int          rq_cyc[$];

  axi_gp_reg_bridge #(.REG_AW(10), .BASE(32'h4000_0000)) dut (
    .CLK(clk), .RST(rst),
    .MAXIGP0_O_AR__ENA(ar_ena), .MAXIGP0_O_AR_addr(ar_addr), .MAXIGP0_O_AR_id(ar_id),
    .MAXIGP0_O_AR_len(ar_len), .MAXIGP0_O_AR__RDY(ar_rdy),
    .MAXIGP0_O_AW__ENA(aw_ena), .MAXIGP0_O_AW_addr(aw_addr), .MAXIGP0_O_AW_id(aw_id),
    .MAXIGP0_O_AW_len(aw_len), .MAXIGP0_O_AW__RDY(aw_rdy),
    .MAXIGP0_O_W__ENA(w_ena), .MAXIGP0_O_W_data(w_data), .MAXIGP0_O_W_id(w_id),
    .MAXIGP0_O_W_last(w_last), .MAXIGP0_O_W__RDY(w_rdy),
    .MAXIGP0_I_R__ENA(r_ena), .MAXIGP0_I_R_data(r_data), .MAXIGP0_I_R_id(r_id),
    .MAXIGP0_I_R_last(r_last), .MAXIGP0_I_R_resp(r_resp), .MAXIGP0_I_R__RDY(r_rdy),
    .MAXIGP0_I_B__ENA(b_ena), .MAXIGP0_I_B_id(b_id), .MAXIGP0_I_B_resp(b_resp),
    .MAXIGP0_I_B__RDY(b_rdy),
    .req__ENA(req_ena), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req__RDY(req_rdy),
    .rsp__ENA(rsp_ena), .rsp_data(rsp_data), .rsp__RDY(rsp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: logs every request, answers reads one cycle after the request.
  task automatic responder();
    bit hit, done;
    int a; logic w; logic [31:0] d;
    forever begin
      @(negedge clk);
      done = rsp_ena && rsp_rdy;
      hit  = req_ena && req_rdy;
      a = int'(req_addr); w = req_write; d = req_data;
      if (hit) begin log_addr.push_back(a); log_wr.push_back(w); log_data.push_back(d); end
      @(posedge clk); #1;
      if (done) rsp_ena = 1'b0;
      if (hit) begin
        if (w) regs[a] = d;
        else begin rsp_ena = 1'b1; rsp_data = regs[a]; end
      end
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_wr.delete(); log_data.delete();
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [11:0] i, input logic [3:0] l,
                         output bit ok, output int acc);
    ar_ena = 1'b1; ar_addr = a; ar_id = i; ar_len = l; ok = 1'b0; acc = -1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); if (ar_rdy) begin ok = 1'b1; acc = cyc; end
      @(posedge clk); #1;
    end
    ar_ena = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [11:0] i, input logic [3:0] l,
                         output bit ok);
    aw_ena = 1'b1; aw_addr = a; aw_id = i; aw_len = l; ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); if (aw_rdy) ok = 1'b1;
      @(posedge clk); #1;
    end
    aw_ena = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic l, output bit ok);
    w_ena = 1'b1; w_data = d; w_last = l; ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); if (w_rdy) ok = 1'b1;
      @(posedge clk); #1;
    end
    w_ena = 1'b0;
  endtask

  task automatic collect_r(input int max_cyc, output bit ok);
    rq_data.delete(); rq_resp.delete(); rq_last.delete(); rq_id.delete(); rq_cyc.delete();
    ok = 1'b0;
    for (int n = 0; n < max_cyc && !ok; n++) begin
      @(negedge clk);
      if (r_ena && r_rdy) begin
        rq_data.push_back(r_data); rq_resp.push_back(r_resp); rq_last.push_back(r_last);
        rq_id.push_back(r_id); rq_cyc.push_back(cyc);
        if (r_last) ok = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_b(output bit ok, output logic [11:0] i, output logic [1:0] rs);
    ok = 1'b0; i = 'x; rs = 'x;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (b_ena && b_rdy) begin ok = 1'b1; i = b_id; rs = b_resp; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({ar_rdy, aw_rdy, w_rdy, r_ena, b_ena, req_ena, rsp_rdy} !== 7'b0)
      $display("FAIL reset_flags got=%b want=0000000",
               {ar_rdy, aw_rdy, w_rdy, r_ena, b_ena, req_ena, rsp_rdy});
    else passes++;
    checks++;
    if ({r_data, req_addr, req_data, r_resp, b_resp, req_write} !== 79'b0)
      $display("FAIL reset_payload r_data=%h req_addr=%0d req_data=%h", r_data, req_addr, req_data);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({ar_rdy, aw_rdy} !== 2'b11) $display("FAIL idle_ready got=%b want=11", {ar_rdy, aw_rdy});
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    string ord = "";
    int nr = 0, nb = 0, ar_cnt = 0;
    bit dual = 1'b0, ar_hit, aw_hit, w_hit;
    logic [11:0] rid[$];
    logic [31:0] rdat[$];
    logic [1:0]  bres = 'x;
    clear_log();
    ar_ena = 1'b1; ar_addr = 32'h4000_0020; ar_id = 12'd1; ar_len = 4'd0;
    aw_ena = 1'b1; aw_addr = 32'h4000_0024; aw_id = 12'd2; aw_len = 4'd0;
    w_ena = 1'b1; w_data = 32'h0000_0077; w_last = 1'b1;
    for (int n = 0; n < 80 && !(nr == 2 && nb == 1); n++) begin
      @(negedge clk);
      ar_hit = ar_ena && ar_rdy; aw_hit = aw_ena && aw_rdy; w_hit = w_ena && w_rdy;
      if (ar_hit && aw_hit) dual = 1'b1;
      if (ar_hit) ord = {ord, "R"};
      if (aw_hit) ord = {ord, "W"};
      if (r_ena && r_rdy) begin nr++; rid.push_back(r_id); rdat.push_back(r_data); end
      if (b_ena && b_rdy) begin nb++; bres = b_resp; end
      @(posedge clk); #1;
      if (ar_hit) begin ar_cnt++; if (ar_cnt == 1) ar_id = 12'd3; else ar_ena = 1'b0; end
      if (aw_hit) aw_ena = 1'b0;
      if (w_hit) w_ena = 1'b0;
    end
    ar_ena = 1'b0; aw_ena = 1'b0; w_ena = 1'b0;
    checks++;
    if (ord != "RWR" || dual) $display("FAIL arb_order got=%s dual=%0d want=RWR", ord, dual);
    else passes++;
    checks++;
    if (nr != 2 || rid.size() != 2 || rid[0] !== 12'd1 || rid[1] !== 12'd3)
      $display("FAIL arb_rids count=%0d want ids 1,3", nr);
    else passes++;
    checks++;
    if (rdat.size() != 2 || rdat[0] !== 32'h0000_0808 || rdat[1] !== 32'h0000_0808)
      $display("FAIL arb_rdata got=%p want 00000808 x2", rdat);
    else passes++;
    checks++;
    if (nb != 1 || bres !== 2'b00) $display("FAIL arb_b count=%0d resp=%b want 1/00", nb, bres);
    else passes++;
  endtask

  task automatic test_single_read();
    bit ok, rok; int acc;
    clear_log();
    send_ar(32'h4000_0010, 12'd5, 4'd0, ok, acc);
    collect_r(20, rok);
    checks++;
    if (!ok || !rok || rq_data.size() != 1) $display("FAIL rd_timeout ar=%0d r=%0d beats=%0d want 1/1/1", ok, rok, rq_data.size());
    else passes++;
    if (rq_data.size() == 1) begin
      checks++;
      if (rq_cyc[0] - acc != 3) $display("FAIL rd_latency got=%0d want=3", rq_cyc[0] - acc);
      else passes++;
      checks++;
      if (rq_data[0] !== 32'hDEAD_BEEF) $display("FAIL rd_data got=%h want=deadbeef", rq_data[0]);
      else passes++;
      checks++;
      if ({rq_id[0], rq_last[0], rq_resp[0]} !== {12'd5, 1'b1, 2'b00})
        $display("FAIL rd_meta id=%0d last=%b resp=%b want 5/1/00", rq_id[0], rq_last[0], rq_resp[0]);
      else passes++;
    end
    checks++;
    if (log_addr.size() != 1 || log_addr[0] != 4 || log_wr[0] !== 1'b0)
      $display("FAIL rd_req entries=%0d want one read of addr 4", log_addr.size());
    else passes++;
  endtask

  task automatic test_write_burst();
    bit ok, wok, bok; bit bad_a = 0, bad_d = 0;
    logic [11:0] bi; logic [1:0] br;
    int exp_a[4] = '{1022, 1023, 0, 1};
    clear_log();
    send_aw(32'h4000_0FF8, 12'd9, 4'd3, ok);
    for (int k = 0; k < 4; k++) begin
      send_w(32'(k + 1), k == 3, wok);
      ok = ok && wok;
    end
    wait_b(bok, bi, br);
    checks++;
    if (!ok || log_addr.size() != 4) $display("FAIL wr_count ok=%0d reqs=%0d want 1/4", ok, log_addr.size());
    else passes++;
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      if (log_addr[k] != exp_a[k] || log_wr[k] !== 1'b1) bad_a = 1;
      if (log_data[k] !== 32'(k + 1)) bad_d = 1;
    end
    checks++;
    if (bad_a) $display("FAIL wr_addr_wrap got=%p want 1022,1023,0,1 writes", log_addr);
    else passes++;
    checks++;
    if (bad_d) $display("FAIL wr_data got=%p want 1,2,3,4", log_data);
    else passes++;
    checks++;
    if (!bok || bi !== 12'd9 || br !== 2'b00) $display("FAIL wr_b ok=%0d id=%0d resp=%b want 1/9/00", bok, bi, br);
    else passes++;
  endtask

  task automatic test_out_of_window();
    bit ok, rok, bok, wok; int acc;
    logic [11:0] bi; logic [1:0] br;
    clear_log();
    send_ar(32'h5000_0000, 12'd3, 4'd1, ok, acc);
    collect_r(20, rok);
    checks++;
    if (!ok || !rok || rq_data.size() != 2) $display("FAIL oow_rbeats got=%0d want=2", rq_data.size());
    else passes++;
    if (rq_data.size() == 2) begin
      checks++;
      if ({rq_data[0], rq_data[1]} !== 64'b0 || {rq_resp[0], rq_resp[1]} !== 4'b1111)
        $display("FAIL oow_rdata data=%h,%h resp=%b,%b want 0,0 11,11", rq_data[0], rq_data[1], rq_resp[0], rq_resp[1]);
      else passes++;
      checks++;
      if ({rq_last[0], rq_last[1]} !== 2'b01) $display("FAIL oow_rlast got=%b%b want=01", rq_last[0], rq_last[1]);
      else passes++;
    end
    send_aw(32'h5000_0000, 12'd6, 4'd0, ok);
    send_w(32'h1234_5678, 1'b1, wok);
    wait_b(bok, bi, br);
    checks++;
    if (!ok || !wok || !bok || br !== 2'b11 || bi !== 12'd6)
      $display("FAIL oow_b ok=%0d%0d%0d resp=%b id=%0d want 111/11/6", ok, wok, bok, br, bi);
    else passes++;
    checks++;
    if (log_addr.size() != 0) $display("FAIL oow_noreq got=%0d requests want=0", log_addr.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok, rok, bok, wok, moved = 0; int acc, seen = 0;
    logic [31:0] d0; logic [11:0] bi; logic [1:0] br;
    clear_log();
    r_rdy = 1'b0;
    send_ar(32'h4000_0040, 12'd11, 4'd1, ok, acc);
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk); if (r_ena) seen = 1;
      @(posedge clk); #1;
    end
    d0 = r_data;
    repeat (5) begin
      @(negedge clk);
      if (!r_ena || r_data !== d0 || r_last !== 1'b0 || r_id !== 12'd11) moved = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok || seen == 0 || moved || d0 !== 32'h0000_AAAA)
      $display("FAIL bp_stable seen=%0d moved=%0d data=%h want 1/0/0000aaaa", seen, moved, d0);
    else passes++;
    checks++;
    if (log_addr.size() != 1) $display("FAIL bp_noreq got=%0d requests want=1", log_addr.size());
    else passes++;
    r_rdy = 1'b1;
    collect_r(20, rok);
    checks++;
    if (!rok || rq_data.size() != 2 || rq_data[0] !== 32'h0000_AAAA || rq_data[1] !== 32'h0000_BBBB
        || log_addr.size() != 2 || log_addr[1] != 17)
      $display("FAIL bp_burst beats=%0d reqs=%0d want 2/2 data aaaa,bbbb", rq_data.size(), log_addr.size());
    else passes++;
    // write with W last on the wrong beat
    clear_log();
    send_aw(32'h4000_0100, 12'd12, 4'd1, ok);
    send_w(32'h0000_0011, 1'b1, wok); ok = ok && wok;
    send_w(32'h0000_0022, 1'b0, wok); ok = ok && wok;
    wait_b(bok, bi, br);
    checks++;
    if (!ok || log_addr.size() != 2 || log_addr[0] != 64 || log_addr[1] != 65)
      $display("FAIL err_writes ok=%0d reqs=%0d want 2 at 64,65", ok, log_addr.size());
    else passes++;
    checks++;
    if (!bok || br !== 2'b10 || bi !== 12'd12) $display("FAIL err_b ok=%0d resp=%b id=%0d want 1/10/12", bok, br, bi);
    else passes++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok, wok, rok, got_b = 0; int acc, seen = 0;
    clear_log();
    send_aw(32'h4000_0000, 12'd7, 4'd3, ok);
    send_w(32'h0000_00A1, 1'b0, wok);
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk); if (w_rdy) seen = 1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || !wok || seen == 0 || {ar_rdy, aw_rdy, w_rdy, r_ena, b_ena, req_ena, rsp_rdy} !== 7'b0)
      $display("FAIL rst_mid_flags got=%b want=0000000",
               {ar_rdy, aw_rdy, w_rdy, r_ena, b_ena, req_ena, rsp_rdy});
    else passes++;
    repeat (10) begin
      @(negedge clk); if (b_ena) got_b = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (got_b || log_addr.size() != 1) $display("FAIL rst_mid_drop b=%0d reqs=%0d want 0/1", got_b, log_addr.size());
    else passes++;
    send_ar(32'h4000_0010, 12'd4, 4'd0, ok, acc);
    collect_r(20, rok);
    checks++;
    if (!ok || !rok || rq_data.size() != 1 || rq_data[0] !== 32'hDEAD_BEEF || rq_id[0] !== 12'd4)
      $display("FAIL rst_mid_read ok=%0d%0d beats=%0d want 11/1 deadbeef id4", ok, rok, rq_data.size());
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    ar_ena = 0; ar_addr = 0; ar_id = 0; ar_len = 0;
    aw_ena = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
    w_ena = 0; w_data = 0; w_id = 0; w_last = 0;
    r_rdy = 1'b1; b_rdy = 1'b1; req_rdy = 1'b1;
    rsp_ena = 1'b0; rsp_data = 0;
    for (int i = 0; i < 1024; i++) regs[i] = 32'h5A5A_0000 | 32'(i);
    regs[4]  = 32'hDEAD_BEEF;
    regs[8]  = 32'h0000_0808;
    regs[16] = 32'h0000_AAAA;
    regs[17] = 32'h0000_BBBB;
    fork responder(); join_none
    test_reset();
    test_arbitration();
    test_single_read();
    test_write_burst();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_gp_reg_bridge.md
Name: axi_gp_reg_bridge

Overview:
- AXI3 slave endpoint that terminates the Zynq PS7 MAXIGP0 master port, sitting directly downstream of the PS7 wrapper.
- Converts AR/AW/W bursts into single-beat word accesses on a simple register request/response interface, and returns R/B responses.
- One transaction is in flight at a time; bursts are serialised beat by beat.
- Replaces the ad-hoc slave logic inside application top levels with one reusable stage.

Parameters:
- REG_AW, 10: word-address width of the register window (4 KiB window at the default).
- BASE, 32'h4000_0000: window base address; bits [REG_AW+1:0] must be zero.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- MAXIGP0_O$AR__ENA / $addr / $id / $len  in  1/32/12/4  read address beat; AR__RDY  out  1.
- MAXIGP0_O$AW__ENA / $addr / $id / $len  in  1/32/12/4  write address beat; AW__RDY  out  1.
- MAXIGP0_O$W__ENA / $data / $id / $last  in  1/32/12/1  write data beat; W__RDY  out  1.
- MAXIGP0_I$R__ENA / $data / $id / $last / $resp  out  1/32/12/1/2  read data beat; R__RDY  in  1.
- MAXIGP0_I$B__ENA / $id / $resp  out  1/12/2  write response; B__RDY  in  1.
- req__ENA / req$write / req$addr / req$data  out  1/1/REG_AW/32  register access; req__RDY  in  1.
- rsp__ENA / rsp$data  in  1/32  read return; rsp__RDY  out  1.

Behaviour:
- Handshake rule, all channels: a beat transfers in any cycle where ENA && RDY. The producer holds its payload and ENA until the transfer.
- Reset values: every __ENA and __RDY output is 0; all payload registers are 0; the FSM is in IDLE.
- Reset asserted mid-burst: the FSM returns to IDLE on the next edge. The in-flight transaction is dropped, with no R or B emitted.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_RESP.
- IDLE:
  - AR__RDY and AW__RDY are asserted only in IDLE.
  - If both AR and AW are valid in the same cycle, a 1-bit round-robin pointer picks the winner (read first after reset) and then toggles. The loser is not accepted.
  - On accept, latch addr, id, len, beat counter = 0, and err flag = 0.
- Window check: the access is in-window iff addr[31:REG_AW+2] == BASE[31:REG_AW+2].
- Register address: req$addr = addr[REG_AW+1:2]. Byte-lane bits [1:0] are ignored.
- Burst addressing: INCR only. The word address increments by 1 per beat and wraps modulo 2^REG_AW inside the window. Beats = len+1.
- Read path:
  - RD_REQ: req__ENA=1, req$write=0. On req__RDY go to RD_WAIT.
  - RD_WAIT: rsp__RDY=1. On rsp__ENA capture rsp$data and go to RD_RESP.
  - RD_RESP: R__ENA=1, id=latched id, last=(beat==len), resp=2'b00. On R__RDY: if last, go to IDLE; else increment beat and go to RD_REQ.
  - Out-of-window read: skip RD_REQ and RD_WAIT. Emit len+1 R beats with data=0 and resp=2'b11.
- Read latency, in-window, zero back-pressure: AR accept at cycle N, req__ENA at N+1, rsp__ENA at N+2 earliest, R__ENA at N+3.
- Write path:
  - WR_DATA: W__RDY=1. On a W beat latch data; if (W$last != (beat==len)), set err. Go to WR_REQ, or for out-of-window stay in WR_DATA counting beats.
  - WR_REQ: req__ENA=1, req$write=1. On req__RDY: if beat==len go to WR_RESP, else increment beat and go to WR_DATA.
  - WR_RESP: B__ENA=1, id=latched id. On B__RDY go to IDLE.
  - B resp priority: out-of-window gives 2'b11; else err gives 2'b10; else 2'b00.
- W$id is not checked.
- Transfer count: exactly len+1 W beats are consumed regardless of W$last.
- rsp__ENA outside RD_WAIT is ignored; rsp__RDY is 0 there.

Decomposition:
- Shared package axi_gp_pkg holds:
  - width constants: ADDR 32, ID 12, LEN 4, DATA 32, RESP 2;
  - resp codes: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11;
  - the FSM state enum.
- No sub-module: a single FSM with a beat counter and the round-robin bit.

Test Plan:
- Single read: AR addr=32'h4000_0010, len=0, id=5; register returns 32'hDEAD_BEEF → req$addr=4, write=0; R data=32'hDEAD_BEEF, id=5, last=1, resp=0; R__ENA 3 cycles after AR accept.
- Write burst: AW addr=32'h4000_0FF8, len=3, W data 1..4 with last on beat 4 → req$addr sequence 1022, 1023, 0, 1 (wrap); one B with resp=0.
- Out-of-window: AR addr=32'h5000_0000, len=1 → no req__ENA; two R beats, data=0, resp=3, last on the 2nd. AW to the same address, len=0 → one W consumed, B resp=3.
- Arbitration: AR and AW valid together right after reset → read accepted first. Both valid again at the next IDLE → write accepted.
- Back-pressure and error: R__RDY held low for 5 cycles → R payload stable, no second req. Write with len=1 and W$last=1 on beat 1 → 2 writes issued, B resp=2.
- Reset mid-burst: RST high for 1 cycle during WR_DATA of a len=3 burst → all ENA/RDY are 0 in the following cycle; no B; IDLE accepts a new AR next.
